jt10_mix: RTL and testbench

- Parametrised, time-multiplexed sound mixer for the YM2610-class top level.
- Generalises the fixed FM/PSG/ADPCM left-right combination to CH signed channel inputs with per-channel programmable gain.
- One shared multiply-accumulate is stepped per cen cycle; the result is saturated and emitted with a sample strobe.
- Sits between the channel generators and the final snd_left/snd_right outputs; one instance per output side.

---
 rtl/jt10_mix.sv | 178 +++++++++++++++++
 tb/tb_jt10_mix.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt10_mix.sv
// rtl/jt10_mix.sv - time-multiplexed CH-channel gain mixer with saturation and sample strobe
// Optional DC blocker after saturation: define JT10_MIX_DCBLOCK_EN.
module jt10_mix #(
    parameter int CH   = 4,
    parameter int WIN  = 16,
    parameter int GW   = 8,
    parameter int WOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [CH*WIN-1:0]   ch_snd,
    input  logic [CH*GW-1:0]    gain,
    input  logic                sample_in,
    input  logic                clr_flags,
    output logic [WOUT-1:0]     snd,
    output logic                snd_sample,
    output logic                busy,
    output logic                clip,
    output logic                overrun
);

    localparam int AW = WIN + GW + 1 + $clog2(CH);
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CH - 1);
    localparam logic signed [AW-1:0] ACC_MAX = AW'((2 ** (WOUT - 1)) - 1);
    localparam logic signed [AW-1:0] ACC_MIN = AW'(-(2 ** (WOUT - 1)));
    localparam logic [WOUT-1:0] OUT_MAX = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic [WOUT-1:0] OUT_MIN = {1'b1, {(WOUT-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [CH*WIN-1:0]      r_ch_shadow;
    logic [CH*GW-1:0]       r_gain_shadow;
    logic signed [AW-1:0]   r_acc;
    logic [WOUT-1:0]        r_snd;
    logic                   r_snd_sample;
    logic                   r_busy;
    logic                   r_clip;
    logic                   r_overrun;

    logic signed [WIN-1:0]  w_cur_ch;
    logic signed [GW:0]     w_cur_g;
    logic signed [AW-1:0]   w_prod;
    logic signed [AW-1:0]   w_shifted;
    logic signed [WOUT-1:0] w_sat;
    logic                   w_sat_clip;
    logic [WOUT-1:0]        w_out;
    logic                   w_out_clip;

    // Gain is unsigned, so a zero MSB makes it a non-negative signed operand
    assign w_cur_ch  = r_ch_shadow[int'(r_idx)*WIN +: WIN];
    assign w_cur_g   = {1'b0, r_gain_shadow[int'(r_idx)*GW +: GW]};
    assign w_prod    = AW'(w_cur_ch) * AW'(w_cur_g);
    assign w_shifted = r_acc >>> 6;

    always_comb begin
        w_sat      = w_shifted[WOUT-1:0];
        w_sat_clip = 1'b0;
        if (w_shifted > ACC_MAX) begin
            w_sat      = OUT_MAX;
            w_sat_clip = 1'b1;
        end else if (w_shifted < ACC_MIN) begin
            w_sat      = OUT_MIN;
            w_sat_clip = 1'b1;
        end
    end

`ifdef JT10_MIX_DCBLOCK_EN
    localparam int DW = WOUT + 2;
    localparam logic signed [DW-1:0] DC_MAX = DW'((2 ** (WOUT - 1)) - 1);
    localparam logic signed [DW-1:0] DC_MIN = DW'(-(2 ** (WOUT - 1)));

    logic signed [WOUT-1:0] r_x_prev;
    logic signed [WOUT-1:0] r_y_prev;
    logic signed [DW-1:0]   w_dc_sum;

    // y = x - x_prev + y_prev - y_prev/256, wide enough that only the final clamp can clip
    assign w_dc_sum = DW'(w_sat) - DW'(r_x_prev) + DW'(r_y_prev) - DW'(r_y_prev >>> 8);

    always_comb begin
        w_out      = w_dc_sum[WOUT-1:0];
        w_out_clip = w_sat_clip;
        if (w_dc_sum > DC_MAX) begin
            w_out      = OUT_MAX;
            w_out_clip = 1'b1;
        end else if (w_dc_sum < DC_MIN) begin
            w_out      = OUT_MIN;
            w_out_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_prev <= '0;
            r_y_prev <= '0;
        end else if (cen && r_state == ST_OUT) begin
            r_x_prev <= w_sat;
            r_y_prev <= w_out;
        end
    end
`else
    assign w_out      = w_sat;
    assign w_out_clip = w_sat_clip;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_ch_shadow   <= '0;
            r_gain_shadow <= '0;
            r_acc         <= '0;
            r_snd         <= '0;
            r_snd_sample  <= 1'b0;
            r_busy        <= 1'b0;
            r_clip        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Strobe drops on every clk edge so it stays one clk wide under cen throttling
            r_snd_sample <= 1'b0;
            if (clr_flags) begin
                r_clip    <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (cen) begin
                case (r_state)
                    ST_IDLE: begin
                        if (sample_in) begin
                            r_ch_shadow   <= ch_snd;
                            r_gain_shadow <= gain;
                            r_acc         <= '0;
                            r_idx         <= '0;
                            r_busy        <= 1'b1;
                            r_state       <= ST_ACC;
                        end
                    end
                    ST_ACC: begin
                        r_acc <= r_acc + w_prod;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_OUT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                        if (sample_in) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    ST_OUT: begin
                        r_snd        <= w_out;
                        r_snd_sample <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                        if (w_out_clip) begin
                            r_clip <= 1'b1;
                        end
                        if (sample_in) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign snd        = r_snd;
    assign snd_sample = r_snd_sample;
    assign busy       = r_busy;
    assign clip       = r_clip;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_jt10_mix.sv
// tb/tb_jt10_mix.sv - directed self-checking bench for jt10_mix
module tb_jt10_mix;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic [63:0] ch_snd;
    logic [31:0] gain;
    logic        sample_in;
    logic        clr_flags;
    logic [15:0] snd;
    logic        snd_sample;
    logic        busy;
    logic        clip;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int strobes;

    always #5 clk = ~clk;

    jt10_mix dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .ch_snd     (ch_snd),
        .gain       (gain),
        .sample_in  (sample_in),
        .clr_flags  (clr_flags),
        .snd        (snd),
        .snd_sample (snd_sample),
        .busy       (busy),
        .clip       (clip),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] c, input logic [31:0] g);
        ch_snd    = c;
        gain      = g;
        sample_in = 1'b1;
        cen       = 1'b1;
        step();
        sample_in = 1'b0;
    endtask

    task automatic wait_strobe(output int l);
        l = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (snd_sample) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int n, output int k);
        k = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (snd_sample) k++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cen       = 1'b0;
        sample_in = 1'b0;
        clr_flags = 1'b0;
        ch_snd    = '0;
        gain      = '0;
        step();
        step();
        check("rst_snd", 32'(snd), 32'h0);
        check("rst_sample", 32'(snd_sample), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_clip", 32'(clip), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        step();

`ifdef JT10_MIX_DCBLOCK_EN
        start({4{16'h1000}}, {4{8'd64}});
        wait_strobe(lat);
        check("dc1_lat", 32'(lat), 32'd5);
        check("dc1_snd", 32'(snd), 32'h4000);
        start({4{16'h1000}}, {4{8'd64}});
        wait_strobe(lat);
        check("dc2_lat", 32'(lat), 32'd5);
        check("dc2_snd", 32'(snd), 32'h3FC0);
        check("dc_clip", 32'(clip), 32'h0);
`else
        // unity gain sum
        start({4{16'h1000}}, {4{8'd64}});
        check("unity_busy", 32'(busy), 32'h1);
        wait_strobe(lat);
        check("unity_lat", 32'(lat), 32'd5);
        check("unity_snd", 32'(snd), 32'h4000);
        check("unity_clip", 32'(clip), 32'h0);
        check("unity_busy_end", 32'(busy), 32'h0);

        // positive saturation, accepted in the IDLE cycle right after OUT
        start({4{16'h7FFF}}, {4{8'd128}});
        wait_strobe(lat);
        check("satp_lat", 32'(lat), 32'd5);
        check("satp_snd", 32'(snd), 32'h7FFF);
        check("satp_clip", 32'(clip), 32'h1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("satp_clr", 32'(clip), 32'h0);

        start({4{16'h8000}}, {4{8'd128}});
        wait_strobe(lat);
        check("satn_snd", 32'(snd), 32'h8000);
        check("satn_clip", 32'(clip), 32'h1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("satn_clr", 32'(clip), 32'h0);

        // mute and mixed signs
        start({16'h0000, 16'h7FFF, 16'hFF00, 16'h0100}, {8'd255, 8'd0, 8'd32, 8'd64});
        ch_snd = {4{16'h7FFF}};
        gain   = {4{8'd255}};
        wait_strobe(lat);
        check("mix_snd", 32'(snd), 32'h0080);
        check("mix_clip", 32'(clip), 32'h0);

        // overrun: second set two cen cycles later is dropped
        start({4{16'h1000}}, {4{8'd64}});
        step();
        ch_snd    = {4{16'h2000}};
        sample_in = 1'b1;
        step();
        sample_in = 1'b0;
        check("ovr_flag", 32'(overrun), 32'h1);
        wait_strobe(lat);
        check("ovr_lat", 32'(lat), 32'd3);
        check("ovr_snd", 32'(snd), 32'h4000);
        count_strobes(10, strobes);
        check("ovr_no_second", 32'(strobes), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        check("ovr_clr", 32'(overrun), 32'h0);
        start({4{16'h0800}}, {4{8'd64}});
        wait_strobe(lat);
        check("ovr_third_lat", 32'(lat), 32'd5);
        check("ovr_third_snd", 32'(snd), 32'h2000);
        check("ovr_third_flag", 32'(overrun), 32'h0);

        // cen high every third clk
        ch_snd    = {4{16'h0400}};
        gain      = {4{8'd64}};
        sample_in = 1'b1;
        cen       = 1'b1;
        step();
        sample_in = 1'b0;
        lat = 0;
        begin
            int ce;
            ce = 0;
            for (int cyc = 1; cyc <= 60; cyc++) begin
                cen = (cyc % 3 == 0);
                step();
                if (cen) ce++;
                if (snd_sample) begin
                    lat = ce;
                    cen = 1'b0;
                    step();
                    check("thr_width", 32'(snd_sample), 32'h0);
                    break;
                end
            end
        end
        check("thr_lat", 32'(lat), 32'd5);
        check("thr_snd", 32'(snd), 32'h1000);
        cen = 1'b1;

        // reset during ACC, with overrun set beforehand
        start({4{16'h1000}}, {4{8'd64}});
        sample_in = 1'b1;
        step();
        sample_in = 1'b0;
        check("rstm_pre_ovr", 32'(overrun), 32'h1);
        rst_n = 1'b0;
        #2;
        check("rstm_snd", 32'(snd), 32'h0);
        check("rstm_sample", 32'(snd_sample), 32'h0);
        check("rstm_busy", 32'(busy), 32'h0);
        check("rstm_clip", 32'(clip), 32'h0);
        check("rstm_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        count_strobes(10, strobes);
        check("rstm_no_strobe", 32'(strobes), 32'd0);
        check("rstm_idle", 32'(busy), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
